io_bridge: RTL and testbench

// - Sits directly downstream of the cpu top-level memory bus (mem_a/mem_dout/mem_wr/mem_din, rdy_in).
// - Splits each bus cycle between the 128KB RAM and the memory-mapped I/O window (a[17:16]==2'b11).
// - Buffers UART output in a TX FIFO and supplies the 0x30004 cycle counter.
// - Drives the cpu ready input so the core freezes while the TX FIFO cannot accept a byte.

---
 rtl/io_bridge.sv | 183 ++++++++++++++++++
 tb/tb_io_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// io_bridge: splits cpu bus cycles between the RAM and the I/O window
// (cpu_a[17:16]==2'b11), buffers UART TX bytes in a FIFO, supplies the
// 0x30004 cycle counter and program-done flag, and holds cpu_rdy low while
// the TX FIFO cannot take another byte.
//
// Ports
//   clk_in, rst_in           clock, async active-low reset
//   cpu_a/cpu_wr/cpu_dout    bus request from the cpu
//   cpu_din                  read data, valid the cycle after the address
//   cpu_rdy                  low freezes the cpu
//   ram_a/ram_wr/ram_dout    RAM request; ram_din returns one cycle later
//   tx_data/tx_valid/tx_ready   UART transmit handshake (FIFO head)
//   rx_data/rx_valid/rx_pop     UART receive side (IO_BRIDGE_RX_EN only)
//   program_done             sticky, set by the write to 0x30004
//
// Build option: define IO_BRIDGE_RX_EN to map the UART receive byte at
// 0x30000 reads; otherwise those reads return 0x00 and rx_pop stays 0.
module io_bridge #(
  parameter int TX_DEPTH_LOG2 = 3,
  parameter int RAM_AW        = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       cpu_a,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              cpu_rdy,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic              program_done
);
  localparam int DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int CW    = TX_DEPTH_LOG2 + 1;
  // Freeze one entry early so a write already on the bus always fits.
  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - 1);

  typedef enum logic [1:0] {SEL_RAM, SEL_RX, SEL_CNT, SEL_ZERO} rd_sel_e;

  // ---------------------------------------------------------------- decode
  logic        io, acc_rd, acc_wr, hit_tx, hit_cnt, hit_stop;
  logic [15:0] io_off;

  assign io       = (cpu_a[17:16] == 2'b11);
  assign io_off   = cpu_a[15:0];
  assign acc_rd   = cpu_rdy & ~cpu_wr;
  assign acc_wr   = cpu_rdy & cpu_wr;
  assign hit_tx   = io & (io_off == 16'h0000);
  assign hit_cnt  = io & (io_off[15:2] == 14'h0001);
  assign hit_stop = io & (io_off == 16'h0004);

  assign ram_a    = cpu_a[RAM_AW-1:0];
  assign ram_dout = cpu_dout;
  assign ram_wr   = cpu_wr & ~io & cpu_rdy;

  logic a_unused;
  assign a_unused = ^cpu_a[31:18];

  // --------------------------------------------------------------- TX FIFO
  logic [TX_DEPTH_LOG2-1:0] wptr, rptr;
  logic [CW-1:0]            tx_count;
  logic [7:0]               mem [DEPTH];
  logic                     push, pop;
  logic [7:0]               push_data;

  // The stop write pushes 0x00 past the zero filter; nothing in the I/O
  // window is writable once program_done is set.
  always_comb begin
    push      = 1'b0;
    push_data = cpu_dout;
    if (acc_wr && !program_done) begin
      if (hit_tx && cpu_dout != 8'h00) begin
        push = 1'b1;
      end else if (hit_stop) begin
        push      = 1'b1;
        push_data = 8'h00;
      end
    end
  end

  assign pop      = tx_valid & tx_ready;
  assign tx_valid = (tx_count != '0);
  assign tx_data  = mem[rptr];
  assign cpu_rdy  = ~(tx_count >= FULL_TH);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wptr     <= '0;
      rptr     <= '0;
      tx_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wptr] <= push_data;
  end

  // ---------------------------------------------------------- program done
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                                  program_done <= 1'b0;
    else if (acc_wr && hit_stop && !program_done) program_done <= 1'b1;
  end

  // -------------------------------------------------------------- RX side
  logic       rx_take;
  logic [7:0] rx_byte_q;

`ifdef IO_BRIDGE_RX_EN
  assign rx_take = acc_rd & hit_tx & rx_valid;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_byte_q <= '0;
      rx_pop    <= 1'b0;
    end else begin
      rx_pop <= rx_take;
      if (rx_take) rx_byte_q <= rx_data;
    end
  end
`else
  logic rx_unused;
  assign rx_take   = 1'b0;
  assign rx_byte_q = '0;
  assign rx_pop    = 1'b0;
  assign rx_unused = ^{rx_data, rx_valid};
`endif

  // ------------------------------------------------- counter and read path
  logic [31:0] cnt, cnt_snap;
  rd_sel_e     rd_sel;
  logic [1:0]  rd_byte;

  // Only the byte-0 read snapshots, so a 4-byte read sequence is coherent.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt      <= '0;
      cnt_snap <= '0;
      rd_sel   <= SEL_RAM;
      rd_byte  <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      if (acc_rd) begin
        rd_byte <= cpu_a[1:0];
        if (!io) begin
          rd_sel <= SEL_RAM;
        end else if (hit_cnt) begin
          rd_sel <= SEL_CNT;
          if (cpu_a[1:0] == 2'b00) cnt_snap <= cnt;
        end else if (rx_take) begin
          rd_sel <= SEL_RX;
        end else begin
          rd_sel <= SEL_ZERO;
        end
      end
    end
  end

  always_comb begin
    cpu_din = '0;
    unique case (rd_sel)
      SEL_RAM:  cpu_din = ram_din;
      SEL_RX:   cpu_din = rx_byte_q;
      SEL_CNT:  cpu_din = cnt_snap[{rd_byte, 3'b000} +: 8];
      default:  cpu_din = '0;
    endcase
  end
endmodule

// File: tb/tb_io_bridge.sv
// Randomized and directed bench for io_bridge. Reference model: a byte
// queue for the TX FIFO, a byte array for RAM contents and an integer
// cycle count, all updated from the bus rules per accepted cycle.
module tb_io_bridge;
  localparam int LOG2  = 3;
  localparam int DEPTH = 1 << LOG2;
  localparam int AW    = 17;

  logic          clk_in = 1'b0, rst_in = 1'b0;
  logic [31:0]   cpu_a = '0;
  logic          cpu_wr = 1'b0;
  logic [7:0]    cpu_dout = '0, cpu_din;
  logic          cpu_rdy;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic [7:0]    ram_dout, ram_din = '0;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0, rx_pop, program_done;

  always #5 clk_in = ~clk_in;

  io_bridge #(.TX_DEPTH_LOG2(LOG2), .RAM_AW(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .program_done(program_done));

  // RAM environment: one-cycle read latency.
  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk_in) begin
    if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  // Reference model state
  logic [7:0]  ref_ram [0:(1<<AW)-1];
  logic [7:0]  q[$];
  logic [7:0]  log_q[$];
  int unsigned cnt_m;
  logic [31:0] snap_m;
  bit          done_m;

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge right after inputs are driven; returns at the next
  // negedge with the read data of this cycle checked.
  task automatic cycle();
    bit          io, rdy_m, pop, exp_vld;
    logic [15:0] off;
    logic [7:0]  head, exp_d;
    #1;
    rdy_m = (q.size() < DEPTH - 1);
    io    = (cpu_a[17:16] == 2'b11);
    off   = cpu_a[15:0];
    chk("rdy", cpu_rdy, rdy_m);
    chk("tx_valid", tx_valid, q.size() > 0);
    chk("done", program_done, done_m);
    chk("rx_pop", rx_pop, 0);
    chk("ram_wr", ram_wr, cpu_wr && !io && rdy_m);
    chk("ram_a", ram_a, cpu_a[16:0]);
    pop  = (q.size() > 0) && tx_ready;
    head = tx_data;
    if (pop) chk("tx_data", tx_data, q[0]);
    @(posedge clk_in);
    if (pop) begin
      void'(q.pop_front());
      log_q.push_back(head);
    end
    exp_vld = 0;
    exp_d   = '0;
    if (rdy_m && cpu_wr) begin
      if (!io) ref_ram[cpu_a[16:0]] = cpu_dout;
      else if (!done_m) begin
        if (off == 16'h0000 && cpu_dout != 8'h00) q.push_back(cpu_dout);
        else if (off == 16'h0004) begin
          q.push_back(8'h00);
          done_m = 1;
        end
      end
    end else if (rdy_m) begin
      exp_vld = 1;
      if (!io) exp_d = ref_ram[cpu_a[16:0]];
      else if (off >= 16'h0004 && off <= 16'h0007) begin
        if (off == 16'h0004) snap_m = cnt_m;
        exp_d = 8'(snap_m >> (8 * (off - 16'h0004)));
      end
    end
    cnt_m++;
    @(negedge clk_in);
    if (exp_vld) chk("din", cpu_din, exp_d);
  endtask

  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_a = a; cpu_wr = wr; cpu_dout = d;
    cycle();
  endtask

  task automatic idle();
    bus(32'h0, 1'b0, 8'h00);
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) idle();
    chk("drained", tx_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0; cpu_wr = 1'b0;
    #2;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_done", program_done, 0);
    chk("rst_rx_pop", rx_pop, 0);
    chk("rst_din", cpu_din, ram_din);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    q.delete(); cnt_m = 0; snap_m = '0; done_m = 0;
  endtask

  logic [7:0] full_bytes [7];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 8'h00;
      ref_ram[i] = 8'h00;
    end
    do_reset();

    // Random mix of RAM traffic, TX writes, counter reads and stray I/O.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] up;
      r        = $urandom_range(0, 9);
      tx_ready = ($urandom_range(0, 1) == 1);
      rx_valid = $urandom_range(0, 1) == 1;
      rx_data  = 8'($urandom);
      up       = $urandom & 32'hFFFC_0000;
      if (r <= 3)      bus($urandom & 32'hFFFC_001F, 1'($urandom), 8'($urandom));
      else if (r == 4) bus(up | 32'h0003_0000, 1'b1, 8'h00);
      else if (r <= 6) bus(up | 32'h0003_0000, 1'b1, 8'($urandom_range(1, 255)));
      else if (r == 7) bus(up | 32'h0003_0004 | 32'($urandom_range(0, 3)), 1'b0, 8'h00);
      else             bus(up | 32'h0003_0008 | 32'($urandom_range(0, 3)), 1'($urandom), 8'($urandom));
    end
    rx_valid = 1'b0;
    drain();

    // Reset mid-stream with bytes queued.
    tx_ready = 1'b0;
    bus(32'h0003_0000, 1'b1, 8'h11);
    bus(32'h0003_0000, 1'b1, 8'h22);
    bus(32'h0003_0000, 1'b1, 8'h33);
    chk("q3_valid", tx_valid, 1);
    do_reset();

    // Counter byte read at cycle 5.
    while (cnt_m < 5) idle();
    bus(32'h0003_0004, 1'b0, 8'h00);
    chk("cnt5", cpu_din, 8'h05);

    // Coherent snapshot across the 0xFF -> 0x100 carry.
    while (cnt_m < 32'hFF) idle();
    bus(32'h0003_0004, 1'b0, 8'h00); chk("coh_b0", cpu_din, 8'hFF);
    bus(32'h0003_0005, 1'b0, 8'h00); chk("coh_b1", cpu_din, 8'h00);
    bus(32'h0003_0006, 1'b0, 8'h00); chk("coh_b2", cpu_din, 8'h00);
    bus(32'h0003_0007, 1'b0, 8'h00); chk("coh_b3", cpu_din, 8'h00);

    // RAM write then read.
    cpu_a = 32'h0000_0123; cpu_wr = 1'b1; cpu_dout = 8'hA5;
    #1;
    chk("ram_wr_pulse", ram_wr, 1);
    chk("ram_a_123", ram_a, 17'h00123);
    cycle();
    cpu_a = 32'h0000_0123; cpu_wr = 1'b0;
    #1;
    chk("ram_wr_low", ram_wr, 0);
    cycle();
    chk("ram_rd", cpu_din, 8'hA5);

    // TX with zero filtering.
    tx_ready = 1'b1;
    log_q.delete();
    bus(32'h0003_0000, 1'b1, 8'h41);
    bus(32'h0003_0000, 1'b1, 8'h00);
    bus(32'h0003_0000, 1'b1, 8'h42);
    repeat (4) idle();
    chk("tx_n", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("tx_0", log_q[0], 8'h41);
      chk("tx_1", log_q[1], 8'h42);
    end

    // Full FIFO backpressure.
    tx_ready = 1'b0;
    log_q.delete();
    for (int i = 0; i < 7; i++) begin
      full_bytes[i] = 8'(8'h60 + i);
      bus(32'h0003_0000, 1'b1, full_bytes[i]);
    end
    #1;
    chk("full_rdy", cpu_rdy, 0);
    repeat (3) bus(32'h0003_0000, 1'b1, 8'h7F);
    drain();
    chk("full_n", log_q.size(), 7);
    for (int i = 0; i < 7 && i < log_q.size(); i++) chk("full_order", log_q[i], full_bytes[i]);
    chk("full_rdy_back", cpu_rdy, 1);

    // Stop write, then a write that must be ignored.
    tx_ready = 1'b0;
    log_q.delete();
    bus(32'h0003_0004, 1'b1, 8'h99);
    #1;
    chk("stop_valid", tx_valid, 1);
    chk("stop_data", tx_data, 8'h00);
    chk("stop_done", program_done, 1);
    bus(32'h0003_0000, 1'b1, 8'h43);
    drain();
    repeat (3) idle();
    chk("stop_n", log_q.size(), 1);
    chk("stop_sticky", program_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
